pmem_arbiter_fsm: RTL

Registered, state-machine-based arbiter that shares the single physical-memory port (cacheline adapter) between the instruction cache and the data cache. It accepts one 256-bit line request at a time and latches address, write data and direction at grant. It holds the transaction on the memory side until `pmem_resp`, then routes the response to the owning cache. It sits between the two L1 caches and the cacheline adapter in the CPU top level.

---
 rtl/pmem_arbiter_fsm.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/pmem_arbiter_fsm.sv
// ---------------------------------------------------------------------------
// pmem_arbiter_fsm
//
// Shares the single physical-memory port (cacheline adapter) between the
// instruction cache and the data cache. One 256-bit line transaction is
// outstanding at a time. Address, write line and direction are latched at
// grant and held on the memory side until pmem_resp; the response is then
// routed to the owning cache in the same cycle.
//
// Optional feature macro: PMEM_ARB_RR_EN
//   defined   -> round-robin on simultaneous I/D requests (the requester
//                not granted last wins); the pointer updates on every grant.
//   undefined -> fixed priority, the D-cache wins every tie; no pointer.
//
// Parameters:
//   ADDR_W  address width (default 32)
//   LINE_W  cacheline width (default 256)
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   instr_read/addr    I-cache line read request and address
//   instr_mem_resp     one-cycle completion pulse to I-cache (combinational)
//   instr_cacheline    read line to I-cache (pmem_rdata while I owns port)
//   data_read/write    D-cache read / write-back request
//   data_addr/wdata    D-cache line address and write-back line
//   data_mem_resp      one-cycle completion pulse to D-cache (combinational)
//   data_cacheline     read line to D-cache (pmem_rdata while D owns port)
//   pmem_read/write    registered commands to the cacheline adapter
//   pmem_address/wdata registered, latched line address / write line
//   pmem_rdata/resp    read line and completion from the adapter
// ---------------------------------------------------------------------------
module pmem_arbiter_fsm #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    // I-cache side
    input  logic              instr_read,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              instr_mem_resp,
    output logic [LINE_W-1:0] instr_cacheline,
    // D-cache side
    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [LINE_W-1:0] data_mem_wdata,
    output logic              data_mem_resp,
    output logic [LINE_W-1:0] data_cacheline,
    // Cacheline adapter side
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_I_BUSY = 2'd1;
    localparam logic [1:0] ST_D_BUSY = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [ADDR_W-1:0] r_pmem_address;
    logic [LINE_W-1:0] r_pmem_wdata;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_i_owner;
    logic              w_d_owner;
    logic              w_resp_done;

    assign w_i_req     = instr_read;
    // A D-cache request with both direction bits set is a write-back.
    assign w_d_req     = data_read | data_write;
    assign w_i_owner   = (r_state == ST_I_BUSY);
    assign w_d_owner   = (r_state == ST_D_BUSY);
    // pmem_resp only means something while a transaction is in flight.
    assign w_resp_done = pmem_resp & (w_i_owner | w_d_owner);

`ifdef PMEM_ARB_RR_EN
    // Remembers which requester won the most recent grant (1 = I-cache).
    logic r_last_i;

    // Round-robin pointer: starts as "last granted I" so D wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_i <= 1'b1;
        end else if (w_grant_i) begin
            r_last_i <= 1'b1;
        end else if (w_grant_d) begin
            r_last_i <= 1'b0;
        end else begin
            r_last_i <= r_last_i;
        end
    end
`endif

    // Grant decision, evaluated only while the port is free.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_i_req && w_d_req) begin
`ifdef PMEM_ARB_RR_EN
                if (r_last_i) begin
                    w_grant_d = 1'b1;
                end else begin
                    w_grant_i = 1'b1;
                end
`else
                w_grant_d = 1'b1;
`endif
            end else if (w_i_req) begin
                w_grant_i = 1'b1;
            end else if (w_d_req) begin
                w_grant_d = 1'b1;
            end else begin
                w_grant_i = 1'b0;
                w_grant_d = 1'b0;
            end
        end else begin
            w_grant_i = 1'b0;
            w_grant_d = 1'b0;
        end
    end

    // Next-state logic; any unreachable encoding falls back to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_i) begin
                    w_next_state = ST_I_BUSY;
                end else if (w_grant_d) begin
                    w_next_state = ST_D_BUSY;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_I_BUSY: begin
                if (pmem_resp) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_I_BUSY;
                end
            end
            ST_D_BUSY: begin
                if (pmem_resp) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_D_BUSY;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Memory commands: set at grant, held through the transaction, cleared
    // on the response edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
        end else if (w_grant_i) begin
            r_pmem_read  <= 1'b1;
            r_pmem_write <= 1'b0;
        end else if (w_grant_d) begin
            r_pmem_read  <= ~data_write;
            r_pmem_write <= data_write;
        end else if (w_resp_done || (w_next_state == ST_IDLE)) begin
            // Second term also scrubs commands if the state ever leaves a
            // legal encoding.
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
        end else begin
            r_pmem_read  <= r_pmem_read;
            r_pmem_write <= r_pmem_write;
        end
    end

    // Latched address / write line; only a grant may change them, so
    // requester-side changes mid-transaction never reach memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pmem_address <= {ADDR_W{1'b0}};
            r_pmem_wdata   <= {LINE_W{1'b0}};
        end else if (w_grant_i) begin
            r_pmem_address <= instr_addr;
            r_pmem_wdata   <= {LINE_W{1'b0}};
        end else if (w_grant_d) begin
            r_pmem_address <= data_addr;
            r_pmem_wdata   <= data_mem_wdata;
        end else begin
            r_pmem_address <= r_pmem_address;
            r_pmem_wdata   <= r_pmem_wdata;
        end
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;

    // Zero-latency response routing; the non-owner never sees a pulse or data.
    assign instr_mem_resp  = w_i_owner & pmem_resp;
    assign data_mem_resp   = w_d_owner & pmem_resp;
    assign instr_cacheline = w_i_owner ? pmem_rdata : {LINE_W{1'b0}};
    assign data_cacheline  = w_d_owner ? pmem_rdata : {LINE_W{1'b0}};

endmodule
